// File: rtl/configurable_bcd_clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : configurable_bcd_clock_pkg
// Description : Shared types, digit widths and reset-time constants for the
//               12/24-hour BCD clock.
// Revision    : 1.0 - initial release
// ============================================================================
package configurable_bcd_clock_pkg;

    typedef enum logic {
        MODE_12H = 1'b0,
        MODE_24H = 1'b1
    } mode_e;

    localparam int C_HT_W = 2;
    localparam int C_HU_W = 4;
    localparam int C_MT_W = 3;
    localparam int C_MU_W = 4;
    localparam int C_ST_W = 3;
    localparam int C_SU_W = 4;

    localparam logic [C_HT_W-1:0] C_RST24_HT = 2'd0;
    localparam logic [C_HU_W-1:0] C_RST24_HU = 4'd0;
    localparam logic [C_HT_W-1:0] C_RST12_HT = 2'd1;
    localparam logic [C_HU_W-1:0] C_RST12_HU = 4'd2;

    // True when every digit is BCD in range and the hour is legal for the mode.
    function automatic logic load_digits_ok(
        input logic              m24,
        input logic [C_HT_W-1:0] ht,
        input logic [C_HU_W-1:0] hu,
        input logic [C_MT_W-1:0] mt,
        input logic [C_MU_W-1:0] mu,
        input logic [C_ST_W-1:0] st,
        input logic [C_SU_W-1:0] su
    );
        logic digits_ok;
        logic hours_ok;
        digits_ok = (hu <= 4'd9) && (mu <= 4'd9) && (su <= 4'd9) &&
                    (mt <= 3'd5) && (st <= 3'd5);
        if (m24)
            hours_ok = (ht < 2'd2) || ((ht == 2'd2) && (hu <= 4'd3));
        else
            hours_ok = ((ht == 2'd0) && (hu != 4'd0)) ||
                       ((ht == 2'd1) && (hu <= 4'd2));
        return digits_ok && hours_ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/configurable_bcd_clock_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_counter
// Description : One modulo-N BCD digit with enable, synchronous load/clear
//               and an enable-qualified carry for chaining.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_counter #(
    parameter int               MODULUS = 10,
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             clr,
    input  logic [WIDTH-1:0] clr_val,
    output logic [WIDTH-1:0] count,
    output logic             carry
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;

    // Priority: load, then clear, then count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_count <= RST_VAL;
        else if (ld)
            r_count <= ld_val;
        else if (clr)
            r_count <= clr_val;
        else if (en)
            r_count <= (r_count == c_max) ? '0 : r_count + WIDTH'(1);
    end

    assign count = r_count;
    assign carry = en && (r_count == c_max);

endmodule
`default_nettype wire

// File: rtl/configurable_bcd_clock.sv
`default_nettype none
// ============================================================================
// Module      : configurable_bcd_clock
// Description : BCD time-of-day clock with prescaler, 12/24-hour modes and
//               validated parallel load.
// Revision    : 1.0 - initial release
// ============================================================================
module configurable_bcd_clock
    import configurable_bcd_clock_pkg::*;
#(
    parameter logic [31:0] TICK_DIV    = 32'd50_000_000,
    parameter bit          DEFAULT_24H = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              load,
    input  logic              mode_24h,
    input  logic [C_HT_W-1:0] ld_hour_tens,
    input  logic [C_HU_W-1:0] ld_hour_units,
    input  logic [C_MT_W-1:0] ld_min_tens,
    input  logic [C_MU_W-1:0] ld_min_units,
    input  logic [C_ST_W-1:0] ld_sec_tens,
    input  logic [C_SU_W-1:0] ld_sec_units,
    input  logic              ld_pm,
    output logic [C_SU_W-1:0] sec_units,
    output logic [C_ST_W-1:0] sec_tens,
    output logic [C_MU_W-1:0] min_units,
    output logic [C_MT_W-1:0] min_tens,
    output logic [C_HU_W-1:0] hour_units,
    output logic [C_HT_W-1:0] hour_tens,
    output logic              pm,
    output logic              is_24h,
    output logic              sec_pulse,
    output logic              load_err
);

    localparam logic [31:0]       c_tick_max = TICK_DIV - 32'd1;
    localparam logic [C_HT_W-1:0] c_rst_ht   = DEFAULT_24H ? C_RST24_HT : C_RST12_HT;
    localparam logic [C_HU_W-1:0] c_rst_hu   = DEFAULT_24H ? C_RST24_HU : C_RST12_HU;
    localparam mode_e             c_rst_mode = DEFAULT_24H ? MODE_24H : MODE_12H;

    logic [31:0] r_presc;
    mode_e       r_mode;
    logic        r_pm;
    logic        r_sec_pulse;
    logic        r_load_err;

    logic w_tick, w_load_ok, w_adv;
    logic w_su_carry, w_st_carry, w_mu_carry, w_hour_adv, w_hu_carry;
    logic w_ht_carry_unused;
    logic w_is24, w_hour_is11, w_hour_is12, w_hour_is23, w_hour_clr;
    logic [C_HU_W-1:0] w_hu_clr_val;

    assign w_is24    = (r_mode == MODE_24H);
    assign w_tick    = run && (r_presc == c_tick_max);
    assign w_load_ok = load && load_digits_ok(mode_24h, ld_hour_tens, ld_hour_units,
                                              ld_min_tens, ld_min_units,
                                              ld_sec_tens, ld_sec_units);
    assign w_adv     = w_tick && !w_load_ok;

    assign w_hour_is11 = (hour_tens == 2'd1) && (hour_units == 4'd1);
    assign w_hour_is12 = (hour_tens == 2'd1) && (hour_units == 4'd2);
    assign w_hour_is23 = (hour_tens == 2'd2) && (hour_units == 4'd3);
    // Hour wrap: 23 -> 00 in 24h mode, 12 -> 01 in 12h mode.
    assign w_hour_clr   = w_hour_adv && (w_is24 ? w_hour_is23 : w_hour_is12);
    assign w_hu_clr_val = w_is24 ? 4'd0 : 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc     <= 32'd0;
            r_mode      <= c_rst_mode;
            r_pm        <= 1'b0;
            r_sec_pulse <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_sec_pulse <= w_adv;
            r_load_err  <= load && !w_load_ok;
            if (w_load_ok) begin
                r_presc <= 32'd0;
                r_mode  <= mode_24h ? MODE_24H : MODE_12H;
                r_pm    <= mode_24h ? 1'b0 : ld_pm;
            end else begin
                if (run)
                    r_presc <= w_tick ? 32'd0 : r_presc + 32'd1;
                if (w_hour_adv && !w_is24 && w_hour_is11)
                    r_pm <= ~r_pm;
            end
        end
    end

    bcd_digit_counter #(.MODULUS(10), .WIDTH(C_SU_W)) u_sec_units (
        .clk(clk), .reset(reset), .en(w_adv), .ld(w_load_ok), .ld_val(ld_sec_units),
        .clr(1'b0), .clr_val('0), .count(sec_units), .carry(w_su_carry)
    );

    bcd_digit_counter #(.MODULUS(6), .WIDTH(C_ST_W)) u_sec_tens (
        .clk(clk), .reset(reset), .en(w_su_carry), .ld(w_load_ok), .ld_val(ld_sec_tens),
        .clr(1'b0), .clr_val('0), .count(sec_tens), .carry(w_st_carry)
    );

    bcd_digit_counter #(.MODULUS(10), .WIDTH(C_MU_W)) u_min_units (
        .clk(clk), .reset(reset), .en(w_st_carry), .ld(w_load_ok), .ld_val(ld_min_units),
        .clr(1'b0), .clr_val('0), .count(min_units), .carry(w_mu_carry)
    );

    bcd_digit_counter #(.MODULUS(6), .WIDTH(C_MT_W)) u_min_tens (
        .clk(clk), .reset(reset), .en(w_mu_carry), .ld(w_load_ok), .ld_val(ld_min_tens),
        .clr(1'b0), .clr_val('0), .count(min_tens), .carry(w_hour_adv)
    );

    bcd_digit_counter #(.MODULUS(10), .WIDTH(C_HU_W), .RST_VAL(c_rst_hu)) u_hour_units (
        .clk(clk), .reset(reset), .en(w_hour_adv), .ld(w_load_ok), .ld_val(ld_hour_units),
        .clr(w_hour_clr), .clr_val(w_hu_clr_val), .count(hour_units), .carry(w_hu_carry)
    );

    bcd_digit_counter #(.MODULUS(3), .WIDTH(C_HT_W), .RST_VAL(c_rst_ht)) u_hour_tens (
        .clk(clk), .reset(reset), .en(w_hu_carry), .ld(w_load_ok), .ld_val(ld_hour_tens),
        .clr(w_hour_clr), .clr_val('0), .count(hour_tens), .carry(w_ht_carry_unused)
    );

    assign pm        = w_is24 ? ((hour_tens == 2'd2) || w_hour_is12 ||
                                 ((hour_tens == 2'd1) && (hour_units > 4'd2)))
                              : r_pm;
    assign is_24h    = w_is24;
    assign sec_pulse = r_sec_pulse;
    assign load_err  = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_configurable_bcd_clock.sv
`default_nettype none
// ============================================================================
// Module      : tb_configurable_bcd_clock
// Description : Scoreboard bench; a seconds-of-day reference model predicts
//               every sec_pulse / load_err event and the time shown with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_configurable_bcd_clock;

    localparam int DIV  = 4;
    localparam bit DEF24 = 1'b0;

    logic       clk = 1'b0;
    logic       reset, run, load, mode_24h, ld_pm;
    logic [1:0] ld_hour_tens;
    logic [3:0] ld_hour_units, ld_min_units, ld_sec_units;
    logic [2:0] ld_min_tens, ld_sec_tens;
    logic [3:0] sec_units, min_units, hour_units;
    logic [2:0] sec_tens, min_tens;
    logic [1:0] hour_tens;
    logic       pm, is_24h, sec_pulse, load_err;

    configurable_bcd_clock #(.TICK_DIV(32'(DIV)), .DEFAULT_24H(DEF24)) dut (
        .clk(clk), .reset(reset), .run(run), .load(load), .mode_24h(mode_24h),
        .ld_hour_tens(ld_hour_tens), .ld_hour_units(ld_hour_units),
        .ld_min_tens(ld_min_tens), .ld_min_units(ld_min_units),
        .ld_sec_tens(ld_sec_tens), .ld_sec_units(ld_sec_units), .ld_pm(ld_pm),
        .sec_units(sec_units), .sec_tens(sec_tens), .min_units(min_units),
        .min_tens(min_tens), .hour_units(hour_units), .hour_tens(hour_tens),
        .pm(pm), .is_24h(is_24h), .sec_pulse(sec_pulse), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit pulse;
        bit err;
        int hour;
        int minute;
        int second;
        bit pm;
        bit m24;
    } ev_t;

    ev_t q[$];
    ev_t e;
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;

    // Reference model: time kept as seconds since midnight.
    int m_sod = 0;
    int m_cnt = 0;
    bit m_24  = DEF24;

    function automatic ev_t snap(input int c, input bit p, input bit er);
        ev_t r;
        int  h24;
        h24      = m_sod / 3600;
        r.cyc    = c;
        r.pulse  = p;
        r.err    = er;
        r.hour   = m_24 ? h24 : ((h24 % 12 == 0) ? 12 : h24 % 12);
        r.minute = (m_sod / 60) % 60;
        r.second = m_sod % 60;
        r.pm     = (h24 >= 12);
        r.m24    = m_24;
        return r;
    endfunction

    function automatic bit load_legal(input bit m24, input int ht, input int hu, input int mt,
                                      input int mu, input int st, input int su);
        int h;
        h = ht * 10 + hu;
        if (hu > 9 || mu > 9 || su > 9 || mt > 5 || st > 5)
            return 1'b0;
        return m24 ? (h <= 23) : (h >= 1 && h <= 12);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Advance one clock edge with the currently driven inputs; predict events.
    task automatic step();
        bit v, tk;
        int h, h24;
        @(posedge clk);
        cyc++;
        v  = load && load_legal(mode_24h, int'(ld_hour_tens), int'(ld_hour_units),
                                int'(ld_min_tens), int'(ld_min_units),
                                int'(ld_sec_tens), int'(ld_sec_units));
        tk = run && (m_cnt == DIV - 1);
        if (v) begin
            h     = int'(ld_hour_tens) * 10 + int'(ld_hour_units);
            h24   = mode_24h ? h : ((h % 12) + (ld_pm ? 12 : 0));
            m_24  = mode_24h;
            m_sod = h24 * 3600 + (int'(ld_min_tens) * 10 + int'(ld_min_units)) * 60
                    + int'(ld_sec_tens) * 10 + int'(ld_sec_units);
            m_cnt = 0;
        end else begin
            if (run)
                m_cnt = tk ? 0 : m_cnt + 1;
            if (tk)
                m_sod = (m_sod + 1) % 86400;
        end
        if ((tk && !v) || (load && !v))
            q.push_back(snap(cyc, tk && !v, load && !v));
        @(negedge clk);
    endtask

    task automatic do_load(input bit m24, input int ht, input int hu, input int mt,
                           input int mu, input int st, input int su, input bit p);
        mode_24h      = m24;
        ld_hour_tens  = 2'(ht);
        ld_hour_units = 4'(hu);
        ld_min_tens   = 3'(mt);
        ld_min_units  = 4'(mu);
        ld_sec_tens   = 3'(st);
        ld_sec_units  = 4'(su);
        ld_pm         = p;
        load          = 1'b1;
        step();
        load          = 1'b0;
        mode_24h      = $urandom_range(0, 1) != 0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_hour", int'(hour_tens) * 10 + int'(hour_units), DEF24 ? 0 : 12);
        chk("rst_min_sec", int'({min_tens, min_units, sec_tens, sec_units}), 0);
        chk("rst_pm", int'(pm), 0);
        chk("rst_is_24h", int'(is_24h), int'(DEF24));
        chk("rst_sec_pulse", int'(sec_pulse), 0);
        chk("rst_load_err", int'(load_err), 0);
        @(negedge clk);
        @(negedge clk);
        m_sod = 0;
        m_cnt = 0;
        m_24  = DEF24;
        reset = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            errors++;
            checks++;
            $display("FAIL missing_event cyc=%0d actual=none required pulse=%0b err=%0b",
                     q[0].cyc, q[0].pulse, q[0].err);
            void'(q.pop_front());
        end
        if (reset === 1'b1 && (sec_pulse === 1'b1 || load_err === 1'b1)) begin
            checks++;
            if (q.size() == 0 || q[0].cyc != cyc) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d actual pulse=%0b err=%0b required none",
                         cyc, sec_pulse, load_err);
            end else begin
                e = q.pop_front();
                if (sec_pulse !== e.pulse || load_err !== e.err || pm !== e.pm ||
                    is_24h !== e.m24 ||
                    int'(hour_tens) * 10 + int'(hour_units) != e.hour ||
                    int'(min_tens) * 10 + int'(min_units) != e.minute ||
                    int'(sec_tens) * 10 + int'(sec_units) != e.second) begin
                    errors++;
                    $display("FAIL event cyc=%0d actual %0d%0d:%0d%0d:%0d%0d pm=%0b 24h=%0b p=%0b e=%0b required %02d:%02d:%02d pm=%0b 24h=%0b p=%0b e=%0b",
                             cyc, hour_tens, hour_units, min_tens, min_units, sec_tens,
                             sec_units, pm, is_24h, sec_pulse, load_err, e.hour, e.minute,
                             e.second, e.pm, e.m24, e.pulse, e.err);
                end
            end
        end
    end

    initial begin
        int h;
        reset = 1'b1; run = 1'b0; load = 1'b0; mode_24h = 1'b0; ld_pm = 1'b0;
        ld_hour_tens = '0; ld_hour_units = '0; ld_min_tens = '0;
        ld_min_units = '0; ld_sec_tens = '0; ld_sec_units = '0;
        @(negedge clk);
        do_reset();

        run = 1'b1;
        repeat (6) step();
        do_load(1, 2, 3, 5, 9, 5, 8, 0);
        repeat (10) step();

        do_load(0, 1, 1, 5, 9, 5, 9, 0);
        repeat (5) step();
        do_load(0, 1, 2, 5, 9, 5, 9, 1);
        repeat (5) step();

        do_load(0, 1, 3, 0, 0, 0, 0, 0);
        repeat (2) step();
        do_load(1, 0, 5, 0, 0, 0, 10, 0);
        repeat (5) step();

        while (m_cnt != DIV - 1) step();
        do_load(0, 0, 9, 5, 9, 5, 7, 1);
        repeat (9) step();

        while (m_cnt != 2) step();
        run = 1'b0;
        repeat (10) step();
        run = 1'b1;
        repeat (6) step();

        while (m_cnt != 2) step();
        do_reset();
        repeat (10) step();

        repeat (1500) begin
            run = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 1) != 0) begin
                    mode_24h = $urandom_range(0, 1) != 0;
                    h = mode_24h ? int'($urandom_range(0, 23)) : int'($urandom_range(1, 12));
                    do_load(mode_24h, h / 10, h % 10, 5, 9, 5,
                            int'($urandom_range(5, 9)), $urandom_range(0, 1) != 0);
                end else begin
                    do_load($urandom_range(0, 1) != 0, int'($urandom_range(0, 3)),
                            int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 15)), $urandom_range(0, 1) != 0);
                end
            end else begin
                step();
            end
        end

        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/configurable_bcd_clock.md
CONFIGURABLE_BCD_CLOCK -- requirements
Module: configurable_bcd_clock

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000: clk cycles per one-second tick; legal range 1 to 2^32-1.
REQ-002 Parameter DEFAULT_24H, default 0: mode after reset (0 = 12-hour, 1 = 24-hour).
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 run  in  1  1 = timekeeping advances; 0 = time and prescaler hold.
REQ-006 load  in  1  one-cycle strobe; writes ld_* fields and mode_24h into time/mode registers.
REQ-007 mode_24h  in  1  mode applied on load.
REQ-008 ld_hour_tens, ld_hour_units, ld_min_tens, ld_min_units, ld_sec_tens, ld_sec_units  in  2/4/3/4/3/4  BCD load value.
REQ-009 ld_pm  in  1  PM flag applied on load in 12-hour mode.
REQ-010 sec_units, sec_tens, min_units, min_tens, hour_units, hour_tens  out  4/3/4/3/4/2  BCD time digits.
REQ-011 pm  out  1  afternoon indicator.
REQ-012 is_24h  out  1  current mode.
REQ-013 sec_pulse  out  1  one-cycle pulse on the cycle the time advances.
REQ-014 load_err  out  1  one-cycle pulse when a load is rejected.

Function
REQ-015 Prescaler: counts 0..TICK_DIV-1 while run=1; tick asserted when count = TICK_DIV-1 and run=1; wraps to 0 on the same edge.
REQ-016 On each tick, time advances by one second on that edge; sec_pulse is registered and high for the following cycle only.
REQ-017 Digit chain: sec_units 0-9, sec_tens 0-5, min_units 0-9, min_tens 0-5; each carry is a synchronous enable, never a derived clock.
REQ-018 24-hour mode: hours 00..23; 23:59:59 -> 00:00:00; pm = 1 when hours >= 12, combinational from the hour digits.
REQ-019 12-hour mode: hour sequence 12, 01, ..., 11, 12; 12:59:59 -> 01:00:00; pm toggles only on 11:59:59 -> 12:00:00.
REQ-020 Load: takes priority over tick; clears the prescaler to 0; suppresses sec_pulse in that cycle.
REQ-021 Load validation: every digit must be BCD in range. Hours must be 00-23 (24h) or 01-12 (12h); otherwise all state is unchanged and load_err pulses for one cycle.
REQ-022 A valid load in 24h mode ignores ld_pm.
REQ-023 run=0 freezes the prescaler value. Resuming continues from the frozen count, with no extra tick.
REQ-024 mode_24h changes without load have no effect.

Reset
REQ-025 While reset=0: prescaler = 0, sec_pulse = 0, load_err = 0, is_24h = DEFAULT_24H.
REQ-026 Reset time is 00:00:00 with pm = 0 when DEFAULT_24H = 1, and 12:00:00 with pm = 0 when DEFAULT_24H = 0.
REQ-027 Reset asserted mid-count aborts the current second; the first tick after release comes TICK_DIV cycles after the first enabled edge.

Structure
REQ-028 Shared package holds: the mode encoding, digit widths, and the reset-time constants for both modes.
REQ-029 One sub-module, bcd_digit_counter, is instantiated per digit, with the following properties:
- parameterised modulus;
- inputs: enable, synchronous load with load value, and synchronous clear to a value;
- outputs: the count, plus a carry equal to enable AND (count = modulus-1).
REQ-030 Hour wrap logic (12/24) lives in the top level, not the sub-module.

Verification
REQ-031 TICK_DIV = 4, 24h: load 23:59:58, run = 1 -> sec_pulse every 4 cycles; sequence 23:59:59, then 00:00:00 with pm = 0.
REQ-032 12h: load 11:59:59 with pm = 0 -> next tick gives 12:00:00, pm = 1. Load 12:59:59 -> next tick gives 01:00:00, pm unchanged.
REQ-033 12h load of hour 13, or 24h load of sec_units = 10 -> load_err for one cycle; time, pm and mode unchanged.
REQ-034 Load asserted on a tick cycle -> loaded value appears, no sec_pulse, next tick TICK_DIV cycles later.
REQ-035 run dropped at prescaler = 2 for 10 cycles, then restored -> tick 1 cycle after restore. Reset pulsed mid-count -> reset time per DEFAULT_24H, prescaler = 0.
